// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator and checker, so both ends
// of a loopback link run the same polynomial.
package lfsr_pkg;
    localparam int               LFSR_W    = 4;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b0011;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;
endpackage

// File: rtl/lfsr_checker_if.sv
// Serial PRBS stream plus checker status, bundled for the loopback sink.
interface lfsr_checker_if #(
    parameter int W     = lfsr_pkg::LFSR_W,
    parameter int ERR_W = 8
);
    logic             DIN;
    logic             VALID;
    logic             CLR;
    logic             LOCKED;
    logic             ERR;
    logic [ERR_W-1:0] ERR_COUNT;
    logic [W-1:0]     WINDOW;

    modport master (output DIN, VALID, CLR, input LOCKED, ERR, ERR_COUNT, WINDOW);
    modport slave  (input DIN, VALID, CLR, output LOCKED, ERR, ERR_COUNT, WINDOW);
endinterface

// File: rtl/lfsr_predict.sv
// Next-bit prediction for a Fibonacci LFSR window (oldest bit at LSB).
module lfsr_predict #(
    parameter int W = lfsr_pkg::LFSR_W
) (
    input  logic [W-1:0] window_i,
    input  logic [W-1:0] taps_i,
    output logic         pred_o
);
    assign pred_o = ^(window_i & taps_i);
endmodule

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises a local LFSR to the incoming
// serial stream, then flags every bit that disagrees with the prediction.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int           W        = LFSR_W,
    parameter logic [W-1:0] TAPS     = LFSR_TAPS,
    parameter int           LOCK_CNT = 4,
    parameter int           LOSS_CNT = 3,
    parameter int           ERR_W    = 8
) (
    input  logic CLK,
    input  logic RST,
    lfsr_checker_if.slave bus
);
    localparam int FILL_W  = $clog2(W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    state_e             state_q, state_d;
    logic [W-1:0]       win_q, win_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   cnt_q, cnt_d;
    logic               pred, din_s, err_inc;

    lfsr_predict #(.W(W)) u_pred (
        .window_i (win_q),
        .taps_i   (TAPS),
        .pred_o   (pred)
    );

    // Gate DIN so an undriven line during idle cycles never reaches state.
    assign din_s = bus.VALID & bus.DIN;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= HUNT;
            win_q   <= '0;
            fill_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        err_inc = 1'b0;

        if (bus.VALID) begin
            unique case (state_q)
                HUNT: begin
                    win_d = {din_s, win_q[W-1:1]};
                    if (fill_q == FILL_W'(W - 1)) begin
                        fill_d = '0;
                        // All-zero is the LFSR lock-up state; keep hunting.
                        if (win_d != '0) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    win_d = {din_s, win_q[W-1:1]};
                    if (din_s == pred) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Regenerate locally so a single corrupted bit costs one error.
                    win_d = {pred, win_q[W-1:1]};
                    if (din_s == pred) begin
                        miss_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                            win_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    win_d   = '0;
                    fill_d  = '0;
                end
            endcase
        end

        // Clear wins over a coincident increment.
        cnt_d = cnt_q;
        if (bus.CLR)
            cnt_d = '0;
        else if (err_inc && (cnt_q != '1))
            cnt_d = cnt_q + ERR_W'(1);
    end

    assign bus.LOCKED    = (state_q == LOCKED);
    assign bus.ERR       = err_q;
    assign bus.ERR_COUNT = cnt_q;
    assign bus.WINDOW    = win_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus queues the expected status per
// VALID bit, a negedge monitor compares the registered outputs.
module tb_lfsr_checker;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    lfsr_checker_if #(.W(4), .ERR_W(8)) bus ();

    lfsr_checker #(
        .W        (4),
        .TAPS     (4'b0011),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .ERR_W    (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic       lk;
        logic       err;
        int         cnt;
        logic       cw;
        logic [3:0] win;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k     = 0;
    int   cnt_m = 0;
    logic smp_vld;
    // Seed 4'b1001 stream, bit i = b[i], period 15: 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0
    logic [14:0] prbs = 15'b000_1111_0101_1001;

    function automatic logic pb(input int i);
        return prbs[i % 15];
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic send(input logic d, input logic lk, input logic err,
                        input logic clr, input logic cw, input logic [3:0] w);
        exp_t x;
        bus.DIN   = d;
        bus.VALID = 1'b1;
        bus.CLR   = clr;
        x = '{lk, err, cnt_m, cw, w};
        q.push_back(x);
        @(posedge CLK);
        #1;
        bus.VALID = 1'b0;
        bus.CLR   = 1'b0;
        bus.DIN   = 1'b0;
    endtask

    // Next stream bit, optionally corrupted; every flip happens while locked.
    task automatic bitk(input logic flip, input logic lk, input logic clr = 1'b0,
                        input logic cw = 1'b0, input logic [3:0] w = 4'd0);
        if (clr) cnt_m = 0;
        else if (flip && cnt_m < 255) cnt_m++;
        send(pb(k) ^ flip, lk, flip, clr, cw, w);
        k++;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.VALID = 1'b0;
            bus.DIN   = 1'($urandom);
            @(posedge CLK);
            #1;
        end
        bus.DIN = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unmatched", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        bus.VALID = 1'b0;
        bus.CLR   = 1'b0;
        bus.DIN   = 1'b0;
        q.delete();
        k     = 0;
        cnt_m = 0;
        RST   = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    always @(posedge CLK or negedge RST) begin
        if (!RST) smp_vld <= 1'b0;
        else      smp_vld <= bus.VALID;
    end

    always @(negedge CLK) begin
        if (RST) begin
            if (smp_vld) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: output with no expectation at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("locked", int'(bus.LOCKED), int'(e.lk));
                    chk("err", int'(bus.ERR), int'(e.err));
                    chk("err_count", int'(bus.ERR_COUNT), e.cnt);
                    if (e.cw) chk("window", int'(bus.WINDOW), int'(e.win));
                end
            end else begin
                chk("err_idle", int'(bus.ERR), 0);
            end
        end
    end

    initial begin
        bus.DIN = 1'b0; bus.VALID = 1'b0; bus.CLR = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk("rst_locked", int'(bus.LOCKED), 0);
        chk("rst_err", int'(bus.ERR), 0);
        chk("rst_count", int'(bus.ERR_COUNT), 0);
        chk("rst_window", int'(bus.WINDOW), 0);
        do_reset();

        // 1: clean stream, lock after the 8th bit
        for (int i = 0; i < 8; i++) bitk(1'b0, i == 7);
        for (int i = 8; i < 20; i++) bitk(1'b0, 1'b1, 1'b0, i == 19, 4'b1100);
        // 2: single flipped bit
        bitk(1'b1, 1'b1);
        for (int i = 21; i < 26; i++) bitk(1'b0, 1'b1);
        // 3: three flips drop lock, then 4 fill + 4 verify bits relock
        bitk(1'b1, 1'b1);
        bitk(1'b1, 1'b1);
        bitk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
        for (int i = 29; i < 36; i++) bitk(1'b0, 1'b0, 1'b0, i == 32, 4'b0010);
        bitk(1'b0, 1'b1);
        bitk(1'b0, 1'b1);
        // CLR alone, then CLR coincident with an error
        bitk(1'b0, 1'b1, 1'b1);
        bitk(1'b1, 1'b1, 1'b1);
        bitk(1'b0, 1'b1);
        bitk(1'b1, 1'b1);
        drain();

        // 6a: async reset while locked with ERR high
        bitk(1'b1, 1'b1);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("arst_locked", int'(bus.LOCKED), 0);
        chk("arst_err", int'(bus.ERR), 0);
        chk("arst_count", int'(bus.ERR_COUNT), 0);
        chk("arst_window", int'(bus.WINDOW), 0);
        do_reset();

        // 4: leading zeros keep the checker hunting
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 1'b0, 1'b0, i == 3, 4'b0000);
        for (int i = 0; i < 8; i++) bitk(1'b0, i == 7);
        bitk(1'b0, 1'b1);
        drain();

        // 5: scenario 1 with random VALID gaps and junk DIN in the gaps
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(1, 0) == 1) gap($urandom_range(2, 1));
            bitk(1'b0, i >= 7);
        end
        gap(2);
        bitk(1'b1, 1'b1);
        gap(3);
        bitk(1'b0, 1'b1);
        drain();

        // 6b: saturation, alternating bad/good bits keeps lock
        bitk(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            bitk(1'b1, 1'b1);
            bitk(1'b0, 1'b1);
        end
        drain();
        chk("sat_count", int'(bus.ERR_COUNT), 255);
        chk("sat_locked", int'(bus.LOCKED), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
